// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter.
// A three-state handshake pops one byte at a time and waits for the transmitter's done flag.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              busy_o,
    output logic [7:0]        txd_data_o,
    output logic              txd_en_o,
    input  logic              txd_flag_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;
    logic [7:0]        txd_data_reg;
    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              pop;

    // Full/empty come from the registered count, so a same-cycle pop never frees room for a write.
    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign wr_accept = wr_en_i && !full;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (txd_flag_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Storage array is left uninitialised on reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= wr_data_i;
        end
    end

    // Registered read port doubles as the byte held for the transmitter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd_data_reg <= 8'h00;
        end else if (pop) begin
            txd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= wr_en_i && full;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({wr_accept, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_reg;
    assign overflow_o = overflow_reg;
    assign busy_o     = (state_reg != IDLE);
    assign txd_en_o   = (state_reg == START);
    assign txd_data_o = txd_data_reg;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter DEPTH, default 16: FIFO depth in bytes; SHALL be a power of two, 2..256.
REQ-003 Parameter ADDR_W, default 4: log2(DEPTH).
REQ-004 Port clk, input, 1: system clock, 100 MHz.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port wr_en_i, input, 1: write strobe; one byte accepted per cycle when high and not full.
REQ-007 Port wr_data_i, input, 8: byte to enqueue.
REQ-008 Port full_o, output, 1: count equals DEPTH.
REQ-009 Port empty_o, output, 1: count equals 0.
REQ-010 Port count_o, output, ADDR_W+1: bytes currently stored (0..DEPTH).
REQ-011 Port overflow_o, output, 1: one-cycle pulse when a write is rejected.
REQ-012 Port busy_o, output, 1: high whenever the FSM is not in IDLE.
REQ-013 Port txd_data_o, output, 8: byte presented to the UART transmitter.
REQ-014 Port txd_en_o, output, 1: one-cycle start pulse to the UART transmitter.
REQ-015 Port txd_flag_i, input, 1: one-cycle "byte transmitted" pulse from the UART transmitter.

Function
REQ-016 Storage SHALL be a circular buffer with ADDR_W-bit read and write pointers; pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 All outputs SHALL be registered or decoded only from registered state.
REQ-018 A write SHALL be accepted when wr_en_i=1 and full_o=0; count_o SHALL reflect it on the next cycle.
REQ-019 A write with full_o=0 SHALL be accepted even if a pop occurs in the same cycle.
REQ-020 A write with full_o=1 SHALL be dropped, even if a pop occurs in the same cycle; overflow_o SHALL pulse high for the next cycle; contents and pointers SHALL be unchanged.
REQ-021 Simultaneous accepted write and pop SHALL leave count_o unchanged.
REQ-022 FSM states SHALL be IDLE, START and WAIT.
REQ-023 IDLE: when empty_o=0, the FSM SHALL pop the head byte into txd_data_o, advance the read pointer, and go to START; otherwise it SHALL stay in IDLE.
REQ-024 START: txd_en_o SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-025 WAIT: on txd_flag_i=1 the FSM SHALL go to IDLE; otherwise it SHALL stay in WAIT indefinitely.
REQ-026 txd_data_o SHALL stay stable from the pop until the next pop.
REQ-027 txd_flag_i SHALL be ignored in IDLE and START.
REQ-028 Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE SHALL be popped at edge N+1; txd_en_o SHALL be high between edges N+1 and N+2.
REQ-029 Back-to-back: if txd_flag_i arrives in WAIT with empty_o=0, the next pop SHALL occur one edge after the return to IDLE, giving a minimum of 2 cycles between the flag and the next txd_en_o.
REQ-030 Bytes SHALL be transmitted in write order with no loss or duplication, except bytes dropped on overflow.

Reset
REQ-031 On rst_n=0 sampled at a clock edge, the block SHALL set:
- pointers and count_o to 0, empty_o=1, full_o=0;
- overflow_o=0, txd_en_o=0, txd_data_o=8'h00, busy_o=0;
- FSM to IDLE.
REQ-032 Reset mid-transfer SHALL discard all stored bytes and abandon WAIT; a late txd_flag_i after reset SHALL be ignored.
REQ-033 Memory contents need not be cleared on reset.

Verification
REQ-034 Single byte: after reset, write 8'h55 at edge N -> txd_data_o=8'h55 and txd_en_o=1 for one cycle at N+1; busy_o=1 until txd_flag_i is pulsed.
REQ-035 Ordering and wrap: write 8'h00..8'h13 (20 bytes) across stalls, answering each txd_en_o with txd_flag_i 10 cycles later -> sequence 8'h00..8'h13 output in order; pointers wrap; no overflow_o.
REQ-036 Overflow: hold txd_flag_i=0 and write 18 bytes -> count_o saturates at 16 (1 byte held in the transmitter); full_o=1; exactly 1 overflow_o pulse for the rejected write.
REQ-037 Full with concurrent pop: with full_o=1 and a pop in the same cycle, write 8'hAA -> write dropped; overflow_o pulses; count_o becomes 15.
REQ-038 Simultaneous write and pop at count_o=3 -> count_o stays 3; the written byte is emitted after the 3 older bytes.
REQ-039 Reset during WAIT with 5 bytes queued -> count_o=0, busy_o=0, txd_en_o=0; a following txd_flag_i pulse causes no txd_en_o.
